// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage that sits directly behind the program counter. It
// owns the sequential fetch address, issues word requests to instruction
// memory over a valid/ready handshake, and buffers the returned instructions
// (each paired with its PC) in an in-order queue that feeds decode. A
// branch/jump redirect flushes the queue and discards any memory responses
// that are still in flight for the abandoned path.
//
// Ports
//   CLK             rising-edge clock
//   RST             asynchronous active-low reset
//   redirect_valid  one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     new fetch address (bits [1:0] ignored)
//   imem_req_valid  request valid towards instruction memory
//   imem_req_addr   request word address (always the current fetch PC)
//   imem_req_ready  memory accepts the request
//   imem_rsp_valid  in-order response valid (no backpressure)
//   imem_rsp_data   fetched instruction
//   out_valid       head queue entry holds an instruction
//   out_pc          PC of the head instruction (0 when out_valid is low)
//   out_instr       head instruction (0 when out_valid is low)
//   out_ready       decode accepts the head entry
//
// Optional build macro
//   FETCH_PERF_EN   adds perf_flush_cnt (accepted redirects) and
//                   perf_stall_cnt (RUN cycles where decode was ready but
//                   nothing was available); both 32-bit, saturating.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  // state | meaning
  // BOOT  | first cycle after reset release, no requests, redirects ignored
  // RUN   | normal fetch: issue requests, fill and drain the queue
  // FLUSH | queue empty, discarding responses of the abandoned path

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   pc_q    [DEPTH];
  logic [XLEN-1:0]   instr_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW-1:0]     fill_ptr;    // oldest allocated entry still waiting for data
  logic [CW-1:0]     count;       // allocated entries (filled or not)
  logic [CW-1:0]     outstanding; // accepted requests whose data will be kept
  logic [CW-1:0]     drop_cnt;    // responses still owed to a flushed path

  logic              req_fire;
  logic              pop;
  logic              rsp_hit_run;
  logic              rsp_hit_flush;
  logic              rsp_fill;
  logic [CW-1:0]     drop_run_next;
  logic [CW-1:0]     drop_flush_next;
  logic [XLEN-1:0]   redirect_aligned;

  // Redirect suppresses the request in its own cycle so nothing new is
  // allocated on the path being abandoned.
  assign imem_req_valid = (state == RUN) && !redirect_valid && (count != FULL);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = (count != '0) && filled_q[head];
  assign out_pc    = out_valid ? pc_q[head]    : '0;
  assign out_instr = out_valid ? instr_q[head] : '0;
  assign pop       = out_valid && out_ready;

  // A response with nothing owed is a protocol error and is ignored.
  assign rsp_hit_run   = imem_rsp_valid && (outstanding != '0);
  assign rsp_hit_flush = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill      = (state == RUN) && !redirect_valid && rsp_hit_run;

  // A response arriving in the redirect cycle belongs to the old path, so it
  // is consumed here rather than counted into the drop budget.
  assign drop_run_next    = outstanding - CW'(rsp_hit_run);
  assign drop_flush_next  = drop_cnt - CW'(rsp_hit_flush);
  assign redirect_aligned = redirect_pc & PC_MASK;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      filled_q    <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            head        <= '0;
            tail        <= '0;
            fill_ptr    <= '0;
            count       <= '0;
            filled_q    <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_run_next;
            fetch_pc    <= redirect_aligned;
            state       <= (outstanding != '0) ? FLUSH : RUN;
          end else begin
            // tail and fill_ptr can only coincide with data owed when the
            // queue is full, and then no request fires, so these never clash.
            if (req_fire) begin
              filled_q[tail] <= 1'b0;
              tail           <= tail + PTR_ONE;
              fetch_pc       <= fetch_pc + PC_STEP;
            end
            if (rsp_fill) begin
              filled_q[fill_ptr] <= 1'b1;
              fill_ptr           <= fill_ptr + PTR_ONE;
            end
            if (pop) begin
              head <= head + PTR_ONE;
            end
            count       <= count + CW'(req_fire) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fill);
          end
        end
        FLUSH: begin
          drop_cnt <= drop_flush_next;
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
          end else if (drop_flush_next == '0) begin
            state <= RUN;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // Payload storage needs no reset: entries are only visible through
  // out_valid, which is governed by count and filled_q.
  always_ff @(posedge CLK) begin
    if (req_fire) begin
      pc_q[tail] <= fetch_pc;
    end
    if (rsp_fill) begin
      instr_q[fill_ptr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic redirect_acc;
  assign redirect_acc = redirect_valid && (state != BOOT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (redirect_acc && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if ((state == RUN) && out_ready && !out_valid && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

  rsp_legal_a: assert property (@(posedge CLK) disable iff (!RST)
    imem_rsp_valid |-> ((outstanding != '0) || (drop_cnt != '0)));

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage directly downstream of the program counter register. It owns the sequential fetch address and issues word requests to instruction memory over a valid/ready handshake. Returned instructions are buffered, paired with their PC, in an in-order queue feeding decode. Branch/jump redirects flush the queue and discard stale memory responses.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries (power of 2, ≥2); bounds in-flight + buffered instructions
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
redirect_valid  input  1  pulse: restart fetch at redirect_pc
redirect_pc  input  XLEN  new fetch address
imem_req_valid  output  1  request valid
imem_req_addr  output  XLEN  request word address
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  in-order response valid, no backpressure
imem_rsp_data  input  XLEN  fetched instruction
out_valid  output  1  head entry holds an instruction
out_pc  output  XLEN  PC of head instruction
out_instr  output  XLEN  head instruction
out_ready  input  1  decode accepts head

Behaviour:
- Reset (RST=0, async): state=BOOT, fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0; imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
- States: BOOT -> RUN unconditionally one cycle after reset release (no request in BOOT). RUN -> FLUSH on redirect when outstanding≠0; RUN -> RUN on redirect when outstanding=0. FLUSH -> RUN when drop_cnt reaches 0.
- Issue: imem_req_valid = (state==RUN) && !redirect_valid && (allocated entries < DEPTH). imem_req_addr = fetch_pc. On req handshake: allocate tail entry {pc=fetch_pc, filled=0}, outstanding+1, fetch_pc += 4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0).
- Response (not dropping): fills oldest unfilled entry, outstanding-1. Memory latency ≥1 cycle, arbitrary.
- Output: out_valid = head allocated && filled. Pop on out_valid && out_ready. Min latency request accept -> out_valid: 1 cycle after response.
- Redirect (any state except BOOT, which ignores it): next cycle queue empty, fetch_pc=redirect_pc with bits[1:0] forced to 0, drop_cnt = outstanding after this cycle's response (response arriving in the redirect cycle is discarded and counted). Pop in same cycle is honoured (decode accepted it); all other entries flushed.
- FLUSH: no requests; each imem_rsp_valid decrements drop_cnt, data discarded. Redirect during FLUSH: fetch_pc reloaded, drop_cnt unchanged except for the current response; stay in FLUSH.
- Full: allocated==DEPTH deasserts imem_req_valid; pop and allocate same cycle legal when count<DEPTH before pop.
- Response with outstanding==0 and drop_cnt==0: protocol error, ignored (assertion in sim).
- Reset mid-operation: immediate return to reset values; in-flight responses after reset are not expected.

Optional Feature:
FETCH_PERF_EN — when defined, adds output perf_flush_cnt [31:0] (counts redirects accepted, saturating at 32'hFFFF_FFFF) and perf_stall_cnt [31:0] (cycles with out_ready=1 and out_valid=0 in RUN, saturating). Both reset to 0. When undefined, ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem ready always, 1-cycle rsp latency, out_ready=1 -> first req in cycle 2 at 0x0, out stream PCs 0x0,0x4,0x8… one per cycle after fill.
- out_ready=0, DEPTH=4 -> exactly 4 requests (0x0–0xC) then imem_req_valid=0; raise out_ready -> pops 0x0,0x4,… and fetch resumes at 0x10.
- 3 outstanding, redirect_pc=0x100 -> FLUSH, 3 responses discarded, next req addr 0x100, first out_pc=0x100.
- Redirect coincident with response and out handshake at 0x8 -> 0x8 accepted once, response dropped, no stale PC after.
- redirect_pc=0xFFFF_FFFE -> fetch at 0xFFFF_FFFC, then 0x0000_0000.
- RST asserted with 2 outstanding -> outputs at reset values asynchronously; restart fetches RESET_PC.
